// File: rtl/stream_demux_n.sv
// stream_demux_n
//   Registered 1-to-NUM_CH stream demultiplexer with valid/ready flow control.
//   Each input word is routed to the channel selected by in_sel and held in a
//   one-entry register for that channel until its sink accepts it. Words
//   addressed to a nonexistent channel are accepted, discarded and counted.
//
//   Optional build macro: DEMUX_BROADCAST_EN adds in_bcast, which loads the
//   input word into every channel at once (accepted only when all are free).
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   input word present
//   in_ready   input word accepted this cycle when in_valid & in_ready
//   in_data    input word
//   in_sel     destination channel index
//   out_valid  bit i: channel i holds a word
//   out_ready  bit i: sink i accepts this cycle
//   out_data   channel i data in bits [i*DATA_W +: DATA_W]
//   drop_cnt   saturating count of discarded words
//   err_pulse  one-cycle pulse per discarded word
//   in_bcast   broadcast request (DEMUX_BROADCAST_EN only)
module stream_demux_n #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     err_pulse
`ifdef DEMUX_BROADCAST_EN
    ,
    input  logic                     in_bcast
`endif
);

    if (NUM_CH < 2 || (2 ** SEL_W) < NUM_CH) begin : g_param_check
        $error("stream_demux_n: need NUM_CH >= 2 and 2**SEL_W >= NUM_CH");
    end

    logic [NUM_CH-1:0]             ch_valid;
    logic [NUM_CH-1:0][DATA_W-1:0] ch_data;

    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] free;
    logic [NUM_CH-1:0] load;
    logic              accept;
    logic              drop;

    // hit is the set of destination channels for the current word; it is
    // empty for an out-of-range select, which makes the AND-reduction below
    // yield in_ready=1 and turns the accept into a drop.
    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            hit[i] = (in_sel == SEL_W'(i));
        end
`ifdef DEMUX_BROADCAST_EN
        if (in_bcast) begin
            hit = '1;
        end
`endif
    end

    // A channel is free when empty or being drained this cycle, so a full
    // channel can be refilled in the same cycle its sink takes the old word.
    assign free     = ~ch_valid | out_ready;
    assign in_ready = &(~hit | free);
    assign accept   = in_valid & in_ready;
    assign load     = hit & {NUM_CH{accept}};
    assign drop     = accept & ~(|hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_valid <= '0;
            ch_data  <= '0;
        end else begin
            // Load wins over drain.
            ch_valid <= (ch_valid & ~out_ready) | load;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (load[i]) begin
                    ch_data[i] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt  <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= drop;
            if (drop && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = ch_valid;
    assign out_data  = ch_data;

endmodule
